// File: rtl/seq_run_detector_pkg.sv
// Shared definitions for the START / BODY-run / END sequence detector.
package seq_run_detector_pkg;

  // Detector FSM states; encodings kept from the original fixed-sequence counter.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GOT_START = 2'd1,
    IN_RUN    = 2'd2
  } state_t;

  // Width needed to hold a BODY run length of 0..max_run.
  function automatic int run_width(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment on the
// same edge yields a count of one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count increments, holding at all-ones; clear restarts from the current increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_run_detector.sv
// Streaming detector: START, then MIN_RUN..MAX_RUN BODY symbols, then END.
// Emits a one-cycle registered pulse on ans and counts matches in hit_cnt.
module seq_run_detector
  import seq_run_detector_pkg::*;
#(
  parameter  int SYM_W   = 2,
  parameter  int MIN_RUN = 2,
  parameter  int MAX_RUN = 7,
  parameter  int CNT_W   = 8,
  localparam int RUN_W   = run_width(MAX_RUN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SYM_W-1:0] num,
  input  logic [SYM_W-1:0] start_sym,
  input  logic [SYM_W-1:0] body_sym,
  input  logic [SYM_W-1:0] end_sym,
  input  logic             hit_clr,
  output logic             ans,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cfg_err
);

  state_t state;
  logic   is_start;
  logic   is_body;
  logic   is_end;
  logic   hit;

  // Symbol decode and configuration sanity check.
  always_comb begin
    is_start = (num == start_sym);
    is_body  = (num == body_sym);
    is_end   = (num == end_sym);
    cfg_err  = (start_sym == body_sym) || (start_sym == end_sym) ||
               (body_sym == end_sym);
  end

  // A completed match: END after a long-enough run; BODY has priority over END.
  always_comb begin
    hit = en && !cfg_err && (state == IN_RUN) && !is_body && is_end &&
          (run_len >= RUN_W'(MIN_RUN));
  end

  // Detector FSM with run-length counter and registered match pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      run_len <= '0;
      ans     <= 1'b0;
    end else begin
      ans <= hit;
      if (cfg_err) begin
        state   <= IDLE;
        run_len <= '0;
      end else if (en) begin
        case (state)
          IDLE: begin
            run_len <= '0;
            state   <= is_start ? GOT_START : IDLE;
          end
          GOT_START: begin
            if (is_body) begin
              state   <= IN_RUN;
              run_len <= RUN_W'(1);
            end else if (is_start) begin
              state   <= GOT_START;
              run_len <= '0;
            end else begin
              state   <= IDLE;
              run_len <= '0;
            end
          end
          IN_RUN: begin
            if (is_body && (run_len < RUN_W'(MAX_RUN))) begin
              run_len <= run_len + RUN_W'(1);
            end else if (is_body) begin
              state   <= IDLE;
              run_len <= '0;
            end else if (is_end) begin
              // Match or too-short run: either way the END is consumed here
              // and never doubles as the next START.
              state   <= IDLE;
              run_len <= '0;
            end else if (is_start) begin
              state   <= GOT_START;
              run_len <= '0;
            end else begin
              state   <= IDLE;
              run_len <= '0;
            end
          end
          default: begin
            state   <= IDLE;
            run_len <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hit_clr),
    .inc   (hit),
    .q     (hit_cnt)
  );

endmodule
